// File: rtl/mat_mul_pkg.sv
// Shared types and elaboration-time helpers for the sequential NxN matrix multiplier.
package mat_mul_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  // Full-precision result width: a product needs 2*dw bits, a sum of n products log2(n) more.
  function automatic int rw(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

  // LSB position of element [i][j] in a row-major bus whose [0][0] sits in the MSB slice.
  function automatic int elem_lsb(input int i, input int j, input int n, input int w);
    return (n * n - 1 - (i * n + j)) * w;
  endfunction

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mat_mac.sv
// Registered multiply-accumulate; acc is the running sum including the current product.
module mat_mac
  import mat_mul_pkg::*;
#(
  parameter int DW     = 8,
  parameter int RW     = 17,
  parameter int SIGNED = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr_acc,
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] y,
  output logic [RW-1:0] acc
);

  localparam int EXT = RW - 2 * DW;

  logic [RW-1:0] acc_q;

  function automatic logic [RW-1:0] ext_prod(input logic [DW-1:0] xv, input logic [DW-1:0] yv);
    logic signed [2*DW-1:0] ps;
    logic        [2*DW-1:0] pu;
    ps = $signed({{DW{xv[DW-1]}}, xv}) * $signed({{DW{yv[DW-1]}}, yv});
    pu = {{DW{1'b0}}, xv} * {{DW{1'b0}}, yv};
    if (SIGNED != 0) return {{EXT{ps[2*DW-1]}}, ps};
    return {{EXT{1'b0}}, pu};
  endfunction

  // Clearing on the first term lets each dot product start without a dead cycle.
  assign acc = (clr_acc ? '0 : acc_q) + ext_prod(x, y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  acc_q <= '0;
    else if (en) acc_q <= acc;
  end

endmodule

// File: rtl/mat_mul_seq.sv
// Sequential NxN matrix multiplier R = A x B using one shared MAC over N^3 cycles.
module mat_mul_seq
  import mat_mul_pkg::*;
#(
  parameter int N      = 2,
  parameter int DW     = 8,
  parameter int SIGNED = 0,
  parameter int RW     = rw(N, DW)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N*N*DW-1:0] a,
  input  logic [N*N*DW-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [N*N*RW-1:0] r
);

  localparam int            CW   = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t            state, state_nxt;
  logic [CW-1:0]     i_q, j_q, k_q;
  logic [N*N*DW-1:0] a_q, b_q;
  logic [DW-1:0]     a_m [N][N];
  logic [DW-1:0]     b_m [N][N];
  logic [RW-1:0]     res_buf [N][N];
  logic [RW-1:0]     res_mrg [N][N];
  logic [N*N*RW-1:0] r_nxt;
  logic [DW-1:0]     x_sel, y_sel;
  logic [RW-1:0]     acc;
  logic              mac_en, k_last, op_last, accept, done_q;

  assign accept  = (state == IDLE) && start;
  assign k_last  = (k_q == LAST);
  assign op_last = mac_en && k_last && (j_q == LAST) && (i_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)   state_nxt = CALC;
      CALC:    if (op_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == CALC);
    mac_en = (state == CALC);
    done   = done_q;
  end

  // Loop nest: k innermost, then j, then i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else if (accept) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else if (mac_en) begin
      if (k_last) begin
        k_q <= '0;
        if (j_q == LAST) begin
          j_q <= '0;
          i_q <= (i_q == LAST) ? '0 : i_q + 1'b1;
        end else begin
          j_q <= j_q + 1'b1;
        end
      end else begin
        k_q <= k_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      r      <= '0;
    end else begin
      done_q <= op_last;
      if (op_last) r <= r_nxt;
    end
  end

  // Operands and the scratch buffer are fully rewritten before use, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b;
    end
  end

  always_ff @(posedge clk) begin
    if (mac_en && k_last) res_buf <= res_mrg;
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      assign a_m[gi][gj] = a_q[elem_lsb(gi, gj, N, DW) +: DW];
      assign b_m[gi][gj] = b_q[elem_lsb(gi, gj, N, DW) +: DW];
      // Fold the element finishing this cycle in, so r never misses the last one.
      assign res_mrg[gi][gj] = (k_last && (i_q == CW'(gi)) && (j_q == CW'(gj)))
                               ? acc : res_buf[gi][gj];
      assign r_nxt[elem_lsb(gi, gj, N, RW) +: RW] = res_mrg[gi][gj];
    end
  end

  assign x_sel = a_m[i_q][k_q];
  assign y_sel = b_m[k_q][j_q];

  mat_mac #(
    .DW    (DW),
    .RW    (RW),
    .SIGNED(SIGNED)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (mac_en),
    .clr_acc(k_q == '0),
    .x      (x_sel),
    .y      (y_sel),
    .acc    (acc)
  );

endmodule

// File: tb/tb_mat_mul_seq.sv
// Directed bench for mat_mul_seq: unsigned 2x2, signed 2x2 and unsigned 3x3 instances.
module tb_mat_mul_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_u, start_s, start_t;
  logic [31:0]  a_u, b_u, a_s, b_s;
  logic [35:0]  a_t, b_t;
  logic         busy_u, busy_s, busy_t;
  logic         done_u, done_s, done_t;
  logic [67:0]  r_u, r_s;
  logic [89:0]  r_t;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mat_mul_seq #(.N(2), .DW(8), .SIGNED(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .start(start_u), .a(a_u), .b(b_u),
    .busy(busy_u), .done(done_u), .r(r_u));

  mat_mul_seq #(.N(2), .DW(8), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .a(a_s), .b(b_s),
    .busy(busy_s), .done(done_s), .r(r_s));

  mat_mul_seq #(.N(3), .DW(4), .SIGNED(0)) dut_t (
    .clk(clk), .rst_n(rst_n), .start(start_t), .a(a_t), .b(b_t),
    .busy(busy_t), .done(done_t), .r(r_t));

  typedef struct {
    int           id;
    logic [63:0]  a;
    logic [63:0]  b;
    logic [127:0] exp;
    int           lat;
    string        nm;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic get_done(input int id);
    case (id)
      0:       return done_u;
      1:       return done_s;
      default: return done_t;
    endcase
  endfunction

  function automatic logic get_busy(input int id);
    case (id)
      0:       return busy_u;
      1:       return busy_s;
      default: return busy_t;
    endcase
  endfunction

  function automatic logic [127:0] get_r(input int id);
    case (id)
      0:       return 128'(r_u);
      1:       return 128'(r_s);
      default: return 128'(r_t);
    endcase
  endfunction

  task automatic set_start(input int id, input logic st);
    case (id)
      0:       start_u = st;
      1:       start_s = st;
      default: start_t = st;
    endcase
  endtask

  task automatic set_in(input int id, input logic [63:0] av, input logic [63:0] bv, input logic st);
    case (id)
      0:       begin a_u = av[31:0]; b_u = bv[31:0]; end
      1:       begin a_s = av[31:0]; b_s = bv[31:0]; end
      default: begin a_t = av[35:0]; b_t = bv[35:0]; end
    endcase
    set_start(id, st);
  endtask

  // Called just after a falling edge; returns at the falling edge where done is seen.
  task automatic run_op(input int id, input logic [63:0] av, input logic [63:0] bv,
                        input logic [127:0] exp, input int lat, input int poke, input string nm);
    int cyc;
    bit both;
    set_in(id, av, bv, 1'b1);
    @(negedge clk);
    set_start(id, 1'b0);
    chk({nm, " busy after start"}, 128'(get_busy(id)), 128'(1));
    cyc  = 1;
    both = 1'b0;
    while (!get_done(id) && cyc < 200) begin
      if (poke != 0 && cyc == poke)          set_in(id, ~av, ~bv, 1'b1);
      else if (poke != 0 && cyc == poke + 1) set_start(id, 1'b0);
      @(negedge clk);
      if (get_done(id) && get_busy(id)) both = 1'b1;
      if (!get_done(id)) cyc++;
    end
    chk({nm, " latency"}, 128'(cyc), 128'(lat));
    chk({nm, " r"}, get_r(id), exp);
    chk({nm, " busy/done overlap"}, 128'(both), 128'(0));
  endtask

  task automatic watch_no_done(input int id, input int ncyc, input string nm);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (get_done(id)) seen = 1'b1;
    end
    chk({nm, " spurious done"}, 128'(seen), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 64'h01020304, 64'h05060708,
                128'({17'd19, 17'd22, 17'd43, 17'd50}), 8, "u basic"};
    vecs[1] = '{0, 64'hFFFFFFFF, 64'hFFFFFFFF,
                128'({4{17'h1FC02}}), 8, "u max"};
    vecs[2] = '{0, 64'h01000001, 64'h05060708,
                128'({17'd5, 17'd6, 17'd7, 17'd8}), 8, "u identity"};
    vecs[3] = '{1, 64'hFF0203FC, 64'h02000002,
                128'({17'h1FFFE, 17'h00004, 17'h00006, 17'h1FFF8}), 8, "s mixed sign"};
    vecs[4] = '{1, 64'h80808080, 64'h80808080,
                128'({4{17'h08000}}), 8, "s most negative"};
    vecs[5] = '{2, 64'h100010001, 64'h123456789,
                128'({10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7, 10'd8, 10'd9}), 27, "t identity"};
    vecs[6] = '{2, 64'hFFFFFFFFF, 64'hFFFFFFFFF,
                128'({9{10'h2A3}}), 27, "t max"};

    rst_n   = 1'b0;
    start_u = 1'b0; start_s = 1'b0; start_t = 1'b0;
    a_u = '0; b_u = '0; a_s = '0; b_s = '0; a_t = '0; b_t = '0;
    repeat (3) @(negedge clk);
    for (int id = 0; id < 3; id++) begin
      chk($sformatf("reset busy %0d", id), 128'(get_busy(id)), 128'(0));
      chk($sformatf("reset done %0d", id), 128'(get_done(id)), 128'(0));
      chk($sformatf("reset r %0d", id), get_r(id), 128'(0));
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      run_op(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].exp, vecs[v].lat, 0, vecs[v].nm);
      @(negedge clk);
      chk({vecs[v].nm, " done pulse width"}, 128'(get_done(vecs[v].id)), 128'(0));
      chk({vecs[v].nm, " r held"}, get_r(vecs[v].id), vecs[v].exp);
    end

    // Start pulsed (with different operands) while busy must be ignored.
    run_op(0, 64'h01020304, 64'h05060708, vecs[0].exp, 8, 3, "ignore");
    watch_no_done(0, 12, "ignore");
    chk("ignore r held", get_r(0), vecs[0].exp);

    // Second start issued in the done cycle: no bubble.
    run_op(0, 64'h01020304, 64'h05060708, vecs[0].exp, 8, 0, "b2b first");
    run_op(0, 64'h01000001, 64'h05060708, vecs[2].exp, 8, 0, "b2b second");
    @(negedge clk);

    // Asynchronous reset in the middle of an operation.
    set_in(0, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b1);
    @(negedge clk);
    set_start(0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset busy", 128'(busy_u), 128'(0));
    chk("midreset done", 128'(done_u), 128'(0));
    chk("midreset r", 128'(r_u), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    watch_no_done(0, 12, "midreset");
    chk("midreset idle", 128'(busy_u), 128'(0));
    run_op(0, 64'h01020304, 64'h05060708, vecs[0].exp, 8, 0, "after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
